// File: rtl/real_part_eq.sv
// Recursive equalizer y[n] = x[n] - a*y[n-2] with divergence flush.
// Build option: define REAL_PART_EQ_LEAK_EN for the leaky form a = 1 - 2^-LEAK_SHIFT.
module real_part_eq #(
  parameter int NB_DATA    = 16,
  parameter int LEAK_SHIFT = 6,
  parameter int SAT_LIMIT  = 4,
  parameter int NB_CNT     = 3
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_valid,
  input  logic [NB_DATA-1:0] i_data,
  input  logic               i_clr_sat,
  output logic               o_valid,
  output logic [NB_DATA-1:0] o_data,
  output logic               o_sat,
  output logic               o_flush
);

  localparam int NB_ACC = NB_DATA + 2;

`ifdef REAL_PART_EQ_LEAK_EN
  localparam bit LEAK_ON = 1'b1;
`else
  localparam bit LEAK_ON = 1'b0;
`endif

  localparam logic signed [NB_ACC-1:0] Y_MAX = {3'b000, {(NB_DATA-1){1'b1}}};
  localparam logic signed [NB_ACC-1:0] Y_MIN = {3'b111, {(NB_DATA-1){1'b0}}};
  localparam logic [NB_CNT-1:0]        RUN_LIMIT = NB_CNT'(SAT_LIMIT);

  typedef enum logic {S_RUN, S_FLUSH} state_t;

  state_t                     state;
  logic signed [NB_DATA-1:0]  y1;
  logic signed [NB_DATA-1:0]  y2;
  logic [NB_CNT-1:0]          run_cnt;
  logic                       flush_cnt;

  logic signed [NB_ACC-1:0]   x_ext;
  logic signed [NB_ACC-1:0]   y2_ext;
  logic signed [NB_ACC-1:0]   leak;
  logic signed [NB_ACC-1:0]   acc;
  logic signed [NB_DATA-1:0]  y_sat;
  logic                       sat_flag;
  logic                       sat_event;
  logic [NB_CNT-1:0]          run_next;

  // The saturated value, not acc, is what feeds the recursion history.
  always_comb begin
    x_ext    = {{2{i_data[NB_DATA-1]}}, i_data};
    y2_ext   = {{2{y2[NB_DATA-1]}}, y2};
    leak     = LEAK_ON ? (y2_ext >>> LEAK_SHIFT) : '0;
    acc      = x_ext - y2_ext + leak;
    y_sat    = acc[NB_DATA-1:0];
    sat_flag = 1'b0;
    if (acc > Y_MAX) begin
      y_sat    = Y_MAX[NB_DATA-1:0];
      sat_flag = 1'b1;
    end else if (acc < Y_MIN) begin
      y_sat    = Y_MIN[NB_DATA-1:0];
      sat_flag = 1'b1;
    end
    sat_event = i_valid && (state == S_RUN) && sat_flag;
    run_next  = run_cnt + 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= S_RUN;
      y1        <= '0;
      y2        <= '0;
      run_cnt   <= '0;
      flush_cnt <= 1'b0;
      o_valid   <= 1'b0;
      o_data    <= '0;
      o_sat     <= 1'b0;
      o_flush   <= 1'b0;
    end else begin
      o_valid <= i_valid;
      // Setting the sticky flag takes priority over a simultaneous clear.
      if (sat_event) begin
        o_sat <= 1'b1;
      end else if (i_clr_sat) begin
        o_sat <= 1'b0;
      end
      if (i_valid) begin
        case (state)
          S_RUN: begin
            o_data <= y_sat;
            if (sat_flag && (run_next == RUN_LIMIT)) begin
              y1        <= '0;
              y2        <= '0;
              run_cnt   <= '0;
              flush_cnt <= 1'b0;
              state     <= S_FLUSH;
              o_flush   <= 1'b1;
            end else begin
              run_cnt <= sat_flag ? run_next : '0;
              y2      <= y1;
              y1      <= y_sat;
            end
          end
          S_FLUSH: begin
            o_data <= '0;
            y1     <= '0;
            y2     <= '0;
            if (flush_cnt) begin
              state   <= S_RUN;
              o_flush <= 1'b0;
            end else begin
              flush_cnt <= 1'b1;
            end
          end
          default: begin
            state   <= S_RUN;
            o_flush <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
